vga_rx_timing: RTL and testbench
================================

Name: vga_rx_timing

Overview:
- Receive-side counterpart of the VGA timing generator: samples hsync/vsync/vga_blank_z and RGB as driven to the DAC.
- Recovers pixel coordinates, measures line and frame timing, and declares lock once timing is stable.
- Used for loopback self-test of the display path and as the front end of any on-chip frame capture logic.
- Runs in the pixel clock domain (sys_clk from the DCM).

Parameters:
- CNT_W, 11, width of all timing counters and measured values.
- LOCK_FRAMES, 2, consecutive matching frames required in VERIFY before lock.
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low; 0 = asserted high.

Ports:
- sys_clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- hsync  in  1  horizontal sync from timing generator.
- vsync  in  1  vertical sync.
- vga_blank_z  in  1  1 = active video, 0 = blanking.
- red/green/blue  in  8 each  pixel data.
- pix_valid  out  1  registered active-video qualifier.
- x_pos  out  CNT_W  recovered column.
- y_pos  out  CNT_W  recovered row.
- rgb_out  out  24  registered {red,green,blue}.
- frame_start  out  1  one-cycle pulse on each vsync assertion edge.
- h_total  out  CNT_W  clocks per line (last completed line).
- v_total  out  CNT_W  lines per frame (last completed frame).
- h_active  out  CNT_W  active pixels in last line.
- v_active  out  CNT_W  active lines in last frame.
- locked  out  1  timing stable.
- timing_err  out  1  one-cycle pulse on a lock-relevant mismatch.

Behaviour:
- Reset: all outputs 0; counters 0; FSM = SEARCH. Reset applied mid-frame takes effect on the next edge, with no partial measurement retained.
- Pipeline:
  - Stage 1 registers all inputs.
  - Stage 2 performs edge detection and registers the outputs.
  - Latency from pins to pix_valid/x_pos/y_pos/rgb_out is 2 cycles.
  - frame_start and measurement updates appear 2 cycles after the sync input edge.
- Sync assertion edge: the transition into the asserted level, per SYNC_ACTIVE_LOW.
- hcnt:
  - Counts clocks since the last hsync edge.
  - On an hsync edge: h_total <= hcnt+1, hcnt <= 0.
  - Saturates at 2^CNT_W-1.
- vcnt:
  - Counts hsync edges since the last vsync edge.
  - On a vsync edge: v_total <= vcnt, vcnt <= 0.
- x_pos:
  - 0 on the first active cycle of a line.
  - Increments each further active cycle.
  - Returns to 0 on the blank_z falling edge.
- y_pos:
  - Increments on each blank_z falling edge.
  - Cleared on a vsync edge.
- h_active: latched on the blank_z falling edge.
- v_active: latched on a vsync edge.
- x_pos/y_pos/pix_valid/rgb_out operate independently of lock.
- Simultaneous hsync and vsync edges: the hsync edge is processed first, so the closing line counts in the ending frame; then the frame is closed.
- FSM:
  - SEARCH: no error reporting. On a vsync edge -> MEASURE.
  - MEASURE: ref_h <= h_total of the first completed line. Any later line with h_total != ref_h, or any saturation, restarts MEASURE at the next vsync edge. At a clean vsync edge: ref_v <= v_total, match_cnt <= 0, -> VERIFY.
  - VERIFY: every line must equal ref_h, and the frame must equal ref_v at its vsync edge. A matching frame increments match_cnt; reaching LOCK_FRAMES -> LOCKED, locked <= 1. On a mismatch or saturation: timing_err pulse, -> MEASURE.
  - LOCKED: on a mismatch or saturation: timing_err pulse, locked <= 0, -> MEASURE.
- Saturation (sync lost) is detected the cycle hcnt reaches 2^CNT_W-1. It is reported once; no repeated timing_err until a sync edge recurs.
- Counter arithmetic is unsigned CNT_W bits, with no wrap (saturating).

Test Plan:
- Lock acquisition:
  - Stimulus: reset, then 640x480 timing (800 clk/line, 96 clk hsync low, 525 lines, 2-line vsync low), LOCK_FRAMES=2.
  - Response: frame_start pulses each frame; locked=1 two cycles after the 4th vsync edge; h_total=800, v_total=525, h_active=640, v_active=480; timing_err never pulses.
- Pixel recovery:
  - Stimulus: drive RGB=0x12/0x34/0x56 on the last active pixel of the last active line.
  - Response: 2 cycles later x_pos=639, y_pos=479, pix_valid=1, rgb_out=0x123456. The next cycle pix_valid=0 and x_pos=0.
- Line-length fault:
  - Stimulus: while locked, stretch one line to 801 clocks.
  - Response: one-cycle timing_err; locked=0; h_total=801. locked returns after 3 further good frames.
- Sync loss:
  - Stimulus: while locked, hold hsync deasserted.
  - Response: timing_err single pulse when hcnt hits 2047; locked=0; no further pulses.
- Reset mid-frame:
  - Stimulus: assert reset for 1 cycle at line 200 while locked.
  - Response: next cycle all outputs 0; FSM SEARCH. Relock only after a full SEARCH->MEASURE->VERIFY sequence.
- Coincident edges:
  - Stimulus: hsync and vsync assert on the same cycle, 525-line frames.
  - Response: v_total=525, no timing_err, lock maintained.

Source files
------------

// File: rtl/vga_rx_timing.sv
// Receive-side VGA timing recovery: registers the DAC-side signals, recovers pixel
// coordinates, measures line/frame geometry and declares lock once timing repeats.
module vga_rx_timing #(
  parameter int CNT_W           = 11,
  parameter int LOCK_FRAMES     = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             vga_blank_z,
  input  logic [7:0]       red,
  input  logic [7:0]       green,
  input  logic [7:0]       blue,
  output logic             pix_valid,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos,
  output logic [23:0]      rgb_out,
  output logic             frame_start,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic             locked,
  output logic             timing_err
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       LOCK_N   = 8'(LOCK_FRAMES);
  localparam logic             SYNC_INV = (SYNC_ACTIVE_LOW != 0);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_VERIFY  = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Syncs are normalised to "1 = asserted" before registering.
  logic [1:0] sync_raw;
  logic [1:0] sync_act;
  assign sync_raw = {vsync, hsync};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync_pol
      assign sync_act[gi] = sync_raw[gi] ^ SYNC_INV;
    end
  endgenerate

  logic        hs_s1_reg, vs_s1_reg, bz_s1_reg;
  logic [23:0] rgb_s1_reg;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      hs_s1_reg  <= 1'b0;
      vs_s1_reg  <= 1'b0;
      bz_s1_reg  <= 1'b0;
      rgb_s1_reg <= '0;
    end else begin
      hs_s1_reg  <= sync_act[0];
      vs_s1_reg  <= sync_act[1];
      bz_s1_reg  <= vga_blank_z;
      rgb_s1_reg <= {red, green, blue};
    end
  end

  logic hs_d_reg, vs_d_reg, bz_d_reg;
  logic hs_edge, vs_edge, bz_rise, bz_fall;

  assign hs_edge = hs_s1_reg & ~hs_d_reg;
  assign vs_edge = vs_s1_reg & ~vs_d_reg;
  assign bz_rise = bz_s1_reg & ~bz_d_reg;
  assign bz_fall = bz_d_reg & ~bz_s1_reg;

  logic [CNT_W-1:0] hcnt_reg, vcnt_reg;
  logic [CNT_W-1:0] line_len, vcnt_upd, y_upd;
  logic             sat_hit;

  // The hsync edge is folded in first so a coincident closing line counts in the ending frame.
  assign line_len = sat_inc(hcnt_reg);
  assign vcnt_upd = hs_edge ? sat_inc(vcnt_reg) : vcnt_reg;
  assign y_upd    = bz_fall ? sat_inc(y_pos) : y_pos;
  assign sat_hit  = ~hs_edge && (hcnt_reg == (CNT_MAX - CNT_ONE));

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] ref_h_reg, ref_h_next;
  logic [CNT_W-1:0] ref_v_reg, ref_v_next;
  logic [7:0]       match_reg, match_next;
  logic             have_ref_reg, have_ref_next;
  logic             meas_bad_reg, meas_bad_next;
  logic             locked_next, err_next;
  logic             line_mis, frame_mis;

  assign line_mis  = hs_edge && (line_len != ref_h_reg);
  assign frame_mis = vs_edge && (vcnt_upd != ref_v_reg);

  always_comb begin
    state_next    = state_reg;
    ref_h_next    = ref_h_reg;
    ref_v_next    = ref_v_reg;
    match_next    = match_reg;
    have_ref_next = have_ref_reg;
    meas_bad_next = meas_bad_reg;
    locked_next   = locked;
    err_next      = 1'b0;
    case (state_reg)
      ST_SEARCH: begin
        if (vs_edge) begin
          state_next    = ST_MEASURE;
          have_ref_next = 1'b0;
          meas_bad_next = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (hs_edge) begin
          if (!have_ref_reg) begin
            ref_h_next    = line_len;
            have_ref_next = 1'b1;
          end else if (line_len != ref_h_reg) begin
            meas_bad_next = 1'b1;
          end
        end
        if (sat_hit) meas_bad_next = 1'b1;
        if (vs_edge) begin
          if (meas_bad_next || !have_ref_next) begin
            have_ref_next = 1'b0;
            meas_bad_next = 1'b0;
          end else begin
            ref_v_next = vcnt_upd;
            match_next = 8'd0;
            state_next = ST_VERIFY;
          end
        end
      end
      default: begin
        if (line_mis || frame_mis || sat_hit) begin
          err_next      = 1'b1;
          locked_next   = 1'b0;
          state_next    = ST_MEASURE;
          have_ref_next = 1'b0;
          // A measurement only counts if it starts on a frame boundary.
          meas_bad_next = ~vs_edge;
        end else if (vs_edge && state_reg == ST_VERIFY) begin
          if (match_reg + 8'd1 == LOCK_N) begin
            state_next  = ST_LOCKED;
            locked_next = 1'b1;
          end else begin
            match_next = match_reg + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      hs_d_reg     <= 1'b0;
      vs_d_reg     <= 1'b0;
      bz_d_reg     <= 1'b0;
      hcnt_reg     <= CNT_ZERO;
      vcnt_reg     <= CNT_ZERO;
      pix_valid    <= 1'b0;
      x_pos        <= CNT_ZERO;
      y_pos        <= CNT_ZERO;
      rgb_out      <= '0;
      frame_start  <= 1'b0;
      h_total      <= CNT_ZERO;
      v_total      <= CNT_ZERO;
      h_active     <= CNT_ZERO;
      v_active     <= CNT_ZERO;
      state_reg    <= ST_SEARCH;
      ref_h_reg    <= CNT_ZERO;
      ref_v_reg    <= CNT_ZERO;
      match_reg    <= 8'd0;
      have_ref_reg <= 1'b0;
      meas_bad_reg <= 1'b0;
      locked       <= 1'b0;
      timing_err   <= 1'b0;
    end else begin
      hs_d_reg    <= hs_s1_reg;
      vs_d_reg    <= vs_s1_reg;
      bz_d_reg    <= bz_s1_reg;
      pix_valid   <= bz_s1_reg;
      rgb_out     <= rgb_s1_reg;
      frame_start <= vs_edge;

      if (hs_edge) begin
        hcnt_reg <= CNT_ZERO;
        h_total  <= line_len;
      end else begin
        hcnt_reg <= sat_inc(hcnt_reg);
      end

      if (vs_edge) begin
        v_total  <= vcnt_upd;
        vcnt_reg <= CNT_ZERO;
        v_active <= y_upd;
        y_pos    <= CNT_ZERO;
      end else begin
        vcnt_reg <= vcnt_upd;
        y_pos    <= y_upd;
      end

      if (bz_rise) begin
        x_pos <= CNT_ZERO;
      end else if (bz_s1_reg) begin
        x_pos <= sat_inc(x_pos);
      end else if (bz_fall) begin
        x_pos    <= CNT_ZERO;
        h_active <= sat_inc(x_pos);
      end

      state_reg    <= state_next;
      ref_h_reg    <= ref_h_next;
      ref_v_reg    <= ref_v_next;
      match_reg    <= match_next;
      have_ref_reg <= have_ref_next;
      meas_bad_reg <= meas_bad_next;
      locked       <= locked_next;
      timing_err   <= err_next;
    end
  end

endmodule

// File: tb/tb_vga_rx_timing.sv
// Bench for vga_rx_timing: pixel-path vector table, then a scaled-down raster
// (40 clk/line, 14 lines/frame) for lock, fault, sync-loss, reset and coincident-edge cases.
module tb_vga_rx_timing;

  localparam int H_TOT = 40;
  localparam int H_ACT = 32;
  localparam int HS_S  = 34;
  localparam int HS_E  = 38;
  localparam int V_TOT = 14;
  localparam int V_ACT = 10;
  localparam int VS_S  = 11;
  localparam int VS_E  = 13;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        hsync, vsync, vga_blank_z;
  logic [7:0]  red, green, blue;
  logic        pix_valid;
  logic [10:0] x_pos, y_pos;
  logic [23:0] rgb_out;
  logic        frame_start;
  logic [10:0] h_total, v_total, h_active, v_active;
  logic        locked, timing_err;

  vga_rx_timing #(.CNT_W(11), .LOCK_FRAMES(2), .SYNC_ACTIVE_LOW(1)) dut (
    .sys_clk(sys_clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .vga_blank_z(vga_blank_z), .red(red), .green(green), .blue(blue),
    .pix_valid(pix_valid), .x_pos(x_pos), .y_pos(y_pos), .rgb_out(rgb_out),
    .frame_start(frame_start), .h_total(h_total), .v_total(v_total),
    .h_active(h_active), .v_active(v_active), .locked(locked), .timing_err(timing_err)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int err_pulses = 0;
  int fs_pulses  = 0;

  always @(negedge sys_clk) begin
    if (timing_err) err_pulses++;
    if (frame_start) fs_pulses++;
  end

  // raster generator state
  int   gh, gv, vs_h, stretch_v, vs_edges;
  bit   hold_sync;
  logic prev_vs;

  typedef struct {
    logic        bz;
    logic        vs;
    logic [23:0] rgb;
    logic        e_pv;
    logic [10:0] e_x;
    logic [10:0] e_y;
    logic        e_fs;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, ".x_pos"}, 32'(x_pos), 32'd0);
    chk({tag, ".y_pos"}, 32'(y_pos), 32'd0);
    chk({tag, ".rgb_out"}, 32'(rgb_out), 32'd0);
    chk({tag, ".frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, ".h_total"}, 32'(h_total), 32'd0);
    chk({tag, ".v_total"}, 32'(v_total), 32'd0);
    chk({tag, ".h_active"}, 32'(h_active), 32'd0);
    chk({tag, ".v_active"}, 32'(v_active), 32'd0);
    chk({tag, ".locked"}, 32'(locked), 32'd0);
    chk({tag, ".timing_err"}, 32'(timing_err), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    vga_blank_z = 1'b0;
    {red, green, blue} = 24'h0;
    repeat (3) @(posedge sys_clk);
    #1;
    reset = 1'b0;
  endtask

  // Advance the raster by one clock and drive the pins for the new position.
  task automatic gen_cycle();
    int  len;
    bit  vs_on;
    @(posedge sys_clk);
    #1;
    len = (gv == stretch_v) ? H_TOT + 1 : H_TOT;
    gh++;
    if (gh >= len) begin
      gh = 0;
      if (gv == stretch_v) stretch_v = -1;
      gv++;
      if (gv >= V_TOT) gv = 0;
    end
    vga_blank_z = (gh < H_ACT) && (gv < V_ACT);
    hsync = hold_sync || !((gh >= HS_S) && (gh < HS_E));
    vs_on = ((gv > VS_S) || (gv == VS_S && gh >= vs_h)) &&
            ((gv < VS_E) || (gv == VS_E && gh < vs_h));
    vsync = hold_sync || !vs_on;
    if (prev_vs && !vsync) vs_edges++;
    prev_vs = vsync;
    if (gh == H_ACT - 1 && gv == V_ACT - 1) {red, green, blue} = 24'h123456;
    else {red, green, blue} = 24'h0;
  endtask

  task automatic wait_vs(input int k);
    int target;
    int n;
    target = vs_edges + k;
    n = 0;
    while (vs_edges < target && n < 1500 * k) begin
      gen_cycle();
      n++;
    end
  endtask

  // Lock must appear exactly two clocks after the 4th vsync edge from here.
  task automatic relock_check(input string tag);
    wait_vs(3);
    gen_cycle(); gen_cycle();
    chk({tag, ".locked_after_3"}, 32'(locked), 32'd0);
    wait_vs(1);
    gen_cycle();
    chk({tag, ".locked_at_4_plus1"}, 32'(locked), 32'd0);
    gen_cycle();
    chk({tag, ".locked_at_4_plus2"}, 32'(locked), 32'd1);
    chk({tag, ".frame_start"}, 32'(frame_start), 32'd1);
  endtask

  initial begin
    int err_snap, fs_snap, n;

    tbl[0]  = '{1'b1, 1'b1, 24'h112233, 1'b1, 11'd0, 11'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 24'h445566, 1'b1, 11'd1, 11'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 24'h778899, 1'b1, 11'd2, 11'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 24'haabbcc, 1'b0, 11'd0, 11'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 24'h000000, 1'b0, 11'd0, 11'd1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 24'h010203, 1'b1, 11'd0, 11'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 24'h040506, 1'b1, 11'd1, 11'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 24'h070809, 1'b0, 11'd0, 11'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 24'h0a0b0c, 1'b0, 11'd0, 11'd0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 24'h0d0e0f, 1'b0, 11'd0, 11'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 24'hffeedd, 1'b1, 11'd0, 11'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 24'h102030, 1'b0, 11'd0, 11'd1, 1'b0};

    hold_sync = 1'b0;
    stretch_v = -1;
    vs_h      = 0;
    vs_edges  = 0;
    prev_vs   = 1'b1;

    do_reset();
    chk_all_zero("reset");

    // pixel path: row i's outputs are due two clocks after it is driven
    for (int i = 0; i < 13; i++) begin
      if (i < 12) begin
        vga_blank_z = tbl[i].bz;
        vsync = tbl[i].vs;
        {red, green, blue} = tbl[i].rgb;
      end
      @(posedge sys_clk);
      #1;
      if (i >= 1) begin
        chk($sformatf("vec%0d.pix_valid", i - 1), 32'(pix_valid), 32'(tbl[i-1].e_pv));
        chk($sformatf("vec%0d.x_pos", i - 1), 32'(x_pos), 32'(tbl[i-1].e_x));
        chk($sformatf("vec%0d.y_pos", i - 1), 32'(y_pos), 32'(tbl[i-1].e_y));
        chk($sformatf("vec%0d.frame_start", i - 1), 32'(frame_start), 32'(tbl[i-1].e_fs));
        chk($sformatf("vec%0d.rgb_out", i - 1), 32'(rgb_out), 32'(tbl[i-1].rgb));
      end
    end
    chk("vec.h_active", 32'(h_active), 32'd1);
    chk("vec.v_active", 32'(v_active), 32'd2);

    // lock acquisition
    do_reset();
    gh = H_TOT - 1;
    gv = V_TOT - 1;
    prev_vs = 1'b1;
    err_snap = err_pulses;
    fs_snap = fs_pulses;
    relock_check("acq");
    gen_cycle();
    chk("acq.frame_start_count", 32'(fs_pulses - fs_snap), 32'd4);
    chk("acq.no_timing_err", 32'(err_pulses - err_snap), 32'd0);
    chk("acq.h_total", 32'(h_total), 32'(H_TOT));
    chk("acq.v_total", 32'(v_total), 32'(V_TOT));
    chk("acq.h_active", 32'(h_active), 32'(H_ACT));
    chk("acq.v_active", 32'(v_active), 32'(V_ACT));

    // last active pixel of last active line
    n = 0;
    while (!(gh == H_ACT - 1 && gv == V_ACT - 1) && n < 2000) begin
      gen_cycle();
      n++;
    end
    gen_cycle(); gen_cycle();
    chk("pix.pix_valid", 32'(pix_valid), 32'd1);
    chk("pix.x_pos", 32'(x_pos), 32'(H_ACT - 1));
    chk("pix.y_pos", 32'(y_pos), 32'(V_ACT - 1));
    chk("pix.rgb_out", 32'(rgb_out), 32'h123456);
    gen_cycle();
    chk("pix.after.pix_valid", 32'(pix_valid), 32'd0);
    chk("pix.after.x_pos", 32'(x_pos), 32'd0);

    // line-length fault: line 3 of the next frame lasts one extra clock
    err_snap = err_pulses;
    stretch_v = 3;
    n = 0;
    while (!timing_err && n < 2000) begin
      gen_cycle();
      n++;
    end
    chk("fault.timing_err", 32'(timing_err), 32'd1);
    chk("fault.locked", 32'(locked), 32'd0);
    chk("fault.h_total", 32'(h_total), 32'(H_TOT + 1));
    gen_cycle();
    chk("fault.err_one_cycle", 32'(timing_err), 32'd0);
    chk("fault.err_pulse_count", 32'(err_pulses - err_snap), 32'd1);
    relock_check("fault_relock");
    chk("fault.no_more_err", 32'(err_pulses - err_snap), 32'd1);

    // reset mid-frame while locked
    n = 0;
    while (gv != 5 && n < 2000) begin
      gen_cycle();
      n++;
    end
    reset = 1'b1;
    gen_cycle();
    reset = 1'b0;
    chk_all_zero("midreset");
    err_snap = err_pulses;
    relock_check("midreset_relock");
    chk("midreset.no_err", 32'(err_pulses - err_snap), 32'd0);

    // coincident hsync/vsync assertion, relocked from a clean start
    n = 0;
    while (gv != 2 && n < 2000) begin
      gen_cycle();
      n++;
    end
    reset = 1'b1;
    vs_h = HS_S;
    gen_cycle();
    reset = 1'b0;
    err_snap = err_pulses;
    relock_check("coinc");
    for (int f = 0; f < 3; f++) begin
      wait_vs(1);
      gen_cycle(); gen_cycle();
      chk($sformatf("coinc.f%0d.locked", f), 32'(locked), 32'd1);
      chk($sformatf("coinc.f%0d.v_total", f), 32'(v_total), 32'(V_TOT));
      chk($sformatf("coinc.f%0d.frame_start", f), 32'(frame_start), 32'd1);
    end
    chk("coinc.h_total", 32'(h_total), 32'(H_TOT));
    chk("coinc.no_err", 32'(err_pulses - err_snap), 32'd0);

    // sync loss: both syncs held deasserted until hcnt saturates
    err_snap = err_pulses;
    hold_sync = 1'b1;
    repeat (2300) gen_cycle();
    chk("syncloss.err_pulse_count", 32'(err_pulses - err_snap), 32'd1);
    chk("syncloss.locked", 32'(locked), 32'd0);
    chk("syncloss.h_total_unchanged", 32'(h_total), 32'(H_TOT));
    repeat (1500) gen_cycle();
    chk("syncloss.no_repeat", 32'(err_pulses - err_snap), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
